// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with input FIFO and back-to-back framing
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic [DATA_BITS-1:0]             pi_data,
  input  logic                             pi_valid,
  output logic                             pi_ready,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_cnt
);
  localparam int BAUD = CLK_FREQ / UART_BPS;
  localparam int BW = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 ||
      STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD < 2) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter set");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  push, pop, baud_end, frame_end;
  assign pi_ready  = cnt_q != CW'(FIFO_DEPTH);
  assign push      = pi_valid && pi_ready;
  assign baud_end  = baud_q == BW'(BAUD - 1);
  assign frame_end = state_q == STOP && baud_end && bit_q == 4'(STOP_BITS - 1);
  // The next word is popped either from IDLE or on the very last stop-bit cycle, so frames chain without a gap
  assign pop       = (state_q == IDLE || frame_end) && cnt_q != '0;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_cnt  = cnt_q;
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = sh_q[0];
        sh_d    = sh_q >> 1;
        par_d   = par_q ^ sh_q[0];
      end
      DATA: if (baud_end) begin
        if (bit_q == 4'(DATA_BITS - 1)) begin
          state_d = (PARITY != 0) ? PAR : STOP;
          tx_d    = (PARITY != 0) ? par_q : 1'b1;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
          tx_d  = sh_q[0];
          sh_d  = sh_q >> 1;
          par_d = par_q ^ sh_q[0];
        end
      end
      PAR: if (baud_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
        bit_d   = '0;
      end
      STOP: if (frame_end) begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end else if (baud_end) begin
        bit_d = bit_q + 1'b1;
      end
      default: ;
    endcase
    // Odd parity seeds the running XOR with 1 so the sent bit makes the total count of ones odd
    if (pop) begin
      state_d = START;
      sh_d    = mem_q[rptr_q];
      par_d   = (PARITY == 1);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      bit_d   = '0;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wptr_q] <= pi_data;
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: four transmitter configurations (8N1, 8E1, 8O1, 7O2) checked cycle by cycle against a frame-level model
module tb_uart_tx_cfg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [8:0] data = '0;
  logic       tx_w [4];
  logic       busy_w [4];
  logic       rdy_w [4];
  logic [2:0] cnt_w [4];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0]  mq [4][4];
  int          mc [4];
  bit          mact [4];
  int          mpos [4];
  int          mlen [4];
  logic [15:0] mfr [4];
  always #5 clk = ~clk;
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[7:0]), .pi_valid(valid),
    .pi_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_cnt(cnt_w[0]));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[7:0]), .pi_valid(valid),
    .pi_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_cnt(cnt_w[1]));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[7:0]), .pi_valid(valid),
    .pi_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_cnt(cnt_w[2]));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[6:0]), .pi_valid(valid),
    .pi_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_cnt(cnt_w[3]));
  function automatic int db(int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int par(int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 1;
  endfunction
  function automatic int sb(int k);
    return (k == 3) ? 2 : 1;
  endfunction
  // Frame as a bit list: start 0, data LSB first, optional parity, stop 1s
  function automatic void load_frame(int k, logic [8:0] w);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < db(k); i++) f[1 + i] = w[i];
    if (par(k) != 0) f[1 + db(k)] = (par(k) == 2) ? ^w : ~^w;
    mfr[k] = f;
    mlen[k] = 1 + db(k) + ((par(k) != 0) ? 1 : 0) + sb(k);
  endfunction
  function automatic logic etx(int k);
    return mact[k] ? mfr[k][mpos[k] / 10] : 1'b1;
  endfunction
  task automatic model_step();
    bit acc;
    int pre;
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        mc[k] = 0;
        mact[k] = 0;
        mpos[k] = 0;
      end else begin
        acc = valid && mc[k] != 4;
        pre = mc[k];
        if (mact[k]) begin
          mpos[k]++;
          if (mpos[k] == mlen[k] * 10) mact[k] = 0;
        end
        if (!mact[k] && pre > 0) begin
          load_frame(k, mq[k][0]);
          for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i + 1];
          mc[k]--;
          mact[k] = 1;
          mpos[k] = 0;
        end
        if (acc) begin
          mq[k][mc[k]] = data & 9'((1 << db(k)) - 1);
          mc[k]++;
        end
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b1;
    data = 9'($urandom);
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (tx_w[k] !== etx(k) || busy_w[k] !== mact[k] || cnt_w[k] !== 3'(mc[k]) || rdy_w[k] !== (mc[k] != 4)) begin
          n_err++;
          $display("FAIL reset u%0d t=%0t tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b/%b", k, $time,
                   tx_w[k], etx(k), busy_w[k], mact[k], cnt_w[k], mc[k], rdy_w[k], mc[k] != 4);
        end
      end
    end
    rst_n = 1'b1;
    valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || cnt_w[k] !== 3'd0 || rdy_w[k] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_release u%0d tx=%b busy=%b cnt=%0d rdy=%b want 1/0/0/1", k, tx_w[k], busy_w[k], cnt_w[k], rdy_w[k]);
      end
    end
  endtask
  task automatic test_single_frames();
    logic [8:0] ws [3];
    ws[0] = 9'h055;
    ws[1] = 9'h007;
    ws[2] = 9'h07F;
    for (int w = 0; w < 3; w++) begin
      valid = 1'b1;
      data = ws[w];
      tick();
      valid = 1'b0;
      data = 9'($urandom);
      for (int c = 1; c <= 115; c++) begin
        tick();
        for (int k = 0; k < 4; k++) begin
          n_cmp++;
          if (tx_w[k] !== etx(k) || busy_w[k] !== mact[k] || cnt_w[k] !== 3'(mc[k]) || rdy_w[k] !== (mc[k] != 4)) begin
            n_err++;
            $display("FAIL single u%0d word=%h c=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b/%b", k, ws[w], c,
                     tx_w[k], etx(k), busy_w[k], mact[k], cnt_w[k], mc[k], rdy_w[k], mc[k] != 4);
          end
        end
        if (w == 0 && (c == 1 || c == 10 || c == 100 || c == 101)) begin
          n_cmp++;
          if (busy_w[0] !== (c != 101) || (c <= 10 && tx_w[0] !== 1'b0)) begin
            n_err++;
            $display("FAIL 8n1_timing c=%0d busy=%b tx=%b", c, busy_w[0], tx_w[0]);
          end
        end
        if (w == 1 && c == 96) begin
          n_cmp++;
          if (tx_w[1] !== 1'b1 || tx_w[2] !== 1'b0) begin
            n_err++;
            $display("FAIL parity_07 even=%b want 1 odd=%b want 0", tx_w[1], tx_w[2]);
          end
        end
        if (w == 2 && (c == 86 || c == 110 || c == 111)) begin
          n_cmp++;
          if ((c == 86 && tx_w[3] !== 1'b0) || (c == 110 && busy_w[3] !== 1'b1) || (c == 111 && busy_w[3] !== 1'b0)) begin
            n_err++;
            $display("FAIL 7o2_frame c=%0d tx=%b busy=%b", c, tx_w[3], busy_w[3]);
          end
        end
      end
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 3200; c++) begin
      valid = (c < 2500) && ($urandom_range(0, 2) == 0);
      data = 9'($urandom);
      tick();
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (tx_w[k] !== etx(k) || busy_w[k] !== mact[k] || cnt_w[k] !== 3'(mc[k]) || rdy_w[k] !== (mc[k] != 4)) begin
          n_err++;
          $display("FAIL random u%0d c=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b/%b", k, c,
                   tx_w[k], etx(k), busy_w[k], mact[k], cnt_w[k], mc[k], rdy_w[k], mc[k] != 4);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [8:0] ws [6];
    int acc_at [6];
    int nsent = 0;
    int nbusy = 0;
    int first_idle = -1;
    bit acc;
    for (int i = 0; i < 6; i++) ws[i] = 9'($urandom);
    for (int c = 0; c < 700; c++) begin
      valid = nsent < 6;
      data = ws[(nsent < 6) ? nsent : 5];
      acc = valid && rdy_w[0];
      tick();
      if (acc) begin
        acc_at[nsent] = c;
        nsent++;
      end
      if (busy_w[0]) nbusy++;
      else if (c > 0 && first_idle < 0) first_idle = c;
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (tx_w[k] !== etx(k) || busy_w[k] !== mact[k] || cnt_w[k] !== 3'(mc[k]) || rdy_w[k] !== (mc[k] != 4)) begin
          n_err++;
          $display("FAIL b2b u%0d c=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b/%b", k, c,
                   tx_w[k], etx(k), busy_w[k], mact[k], cnt_w[k], mc[k], rdy_w[k], mc[k] != 4);
        end
      end
    end
    valid = 1'b0;
    n_cmp++;
    if (nsent != 6 || acc_at[0] != 0 || acc_at[1] != 1 || acc_at[2] != 2 || acc_at[3] != 3 || acc_at[4] != 4 || acc_at[5] != 102) begin
      n_err++;
      $display("FAIL b2b_accept n=%0d at %0d,%0d,%0d,%0d,%0d,%0d want 6 at 0,1,2,3,4,102", nsent,
               acc_at[0], acc_at[1], acc_at[2], acc_at[3], acc_at[4], acc_at[5]);
    end
    n_cmp++;
    if (nbusy != 600 || first_idle != 601) begin
      n_err++;
      $display("FAIL b2b_contiguous busy_cycles=%0d first_idle=%0d want 600/601", nbusy, first_idle);
    end
  endtask
  task automatic test_reset_midframe();
    int nbusy = 0;
    for (int c = 0; c < 200; c++) begin
      valid = c < 3;
      data = 9'($urandom);
      rst_n = (c != 36);
      tick();
      if (c == 36) begin
        n_cmp++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) begin
          n_err++;
          $display("FAIL midframe_reset tx=%b busy=%b cnt=%0d want 1/0/0", tx_w[0], busy_w[0], cnt_w[0]);
        end
      end
      if (c > 36 && busy_w[0]) nbusy++;
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (tx_w[k] !== etx(k) || busy_w[k] !== mact[k] || cnt_w[k] !== 3'(mc[k]) || rdy_w[k] !== (mc[k] != 4)) begin
          n_err++;
          $display("FAIL midframe u%0d c=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b/%b", k, c,
                   tx_w[k], etx(k), busy_w[k], mact[k], cnt_w[k], mc[k], rdy_w[k], mc[k] != 4);
        end
      end
    end
    rst_n = 1'b1;
    n_cmp++;
    if (nbusy != 0) begin
      n_err++;
      $display("FAIL midframe_no_resume busy_cycles=%0d want 0", nbusy);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single_frames();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
